// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
//   SPI slave front end for a small RAM. It decodes a serial command word of
//   DATA_W+2 bits (2-bit opcode followed by an address or data byte) and
//   presents it in parallel with a one-cycle strobe. For a read-data command,
//   it serializes the byte that the RAM returns back onto MISO.
//
//   The SPI serial clock is the block clock. All logic runs on the rising edge.
//
// Ports
//   clk       in   single clock, also the SPI serial clock
//   rst_n     in   asynchronous active-low reset
//   SS_n      in   active-low slave select, low frames a transaction
//   MOSI      in   serial command/data in, MSB first
//   MISO      out  serial read data out, MSB first, registered
//   rx_data   out  [DATA_W+1:0] parallel command word, [DATA_W+1:DATA_W] opcode
//                  (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data)
//   rx_valid  out  one-cycle strobe qualifying rx_data
//   tx_data   in   [DATA_W-1:0] read byte returned by the RAM
//   tx_valid  in   qualifies tx_data, may be held high for several cycles
// ---------------------------------------------------------------------------
module spi_slave #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int CW    = DATA_W + 2;
  localparam int CNT_W = $clog2(DATA_W + 2);

  // The body counter and the serializer counter both stop at DATA_W.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // Command receive path
  logic [CW-2:0]      r_rxShift;
  logic [CNT_W-1:0]   r_bitCnt;
  logic               r_cmdDone;
  logic [CW-1:0]      r_rxData;
  logic               r_rxValid;

  // Remembers that a read address was delivered, so the next 1-prefixed
  // frame is treated as the read-data transfer.
  logic               r_rdAddrFlag;

  // Read-data serializer
  logic [DATA_W-1:0]  r_txShift;
  logic [CNT_W-1:0]   r_txCnt;
  logic               r_txBusy;
  logic               r_txDone;
  logic               r_miso;

  // Set once SS_n has been seen high after reset. A frame can only start
  // from a fresh SS_n falling edge, not from SS_n already low at release.
  logic               r_armed;

  logic               w_inBody;
  logic               w_shiftIn;
  logic               w_lastBit;
  logic               w_txCapture;

  assign MISO     = r_miso;
  assign rx_data  = r_rxData;
  assign rx_valid = r_rxValid;

  assign w_inBody    = (r_state == WRITE) || (r_state == READ_ADD) ||
                       (r_state == READ_DATA);
  assign w_shiftIn   = w_inBody && !r_cmdDone && !SS_n;
  assign w_lastBit   = w_shiftIn && (r_bitCnt == LAST_CNT);

  // The RAM byte is taken on the first tx_valid after the command word,
  // and never again within the same frame.
  assign w_txCapture = (r_state == READ_DATA) && r_cmdDone && !r_txBusy &&
                       !r_txDone && tx_valid && !SS_n;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode. SS_n high returns to IDLE from any state. The body
  // states are left only that way, so bits after a completed word are ignored.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (!SS_n && r_armed) begin
          w_nextState = CHK_CMD;
        end
      end
      CHK_CMD: begin
        if (!MOSI) begin
          w_nextState = WRITE;
        end else if (r_rdAddrFlag) begin
          w_nextState = READ_DATA;
        end else begin
          w_nextState = READ_ADD;
        end
      end
      WRITE, READ_ADD, READ_DATA: begin
        w_nextState = r_state;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
    if (SS_n) begin
      w_nextState = IDLE;
    end
  end

  // Receive shifter and word strobe. CHK_CMD loads the opcode MSB. The body
  // states shift DATA_W+1 further bits. The final bit goes straight into
  // rx_data, so the word appears complete together with the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxShift    <= '0;
      r_bitCnt     <= '0;
      r_cmdDone    <= 1'b0;
      r_rxData     <= '0;
      r_rxValid    <= 1'b0;
      r_armed      <= 1'b0;
    end else begin
      r_rxValid <= 1'b0;
      if (SS_n) begin
        r_armed   <= 1'b1;
        r_rxShift <= '0;
        r_bitCnt  <= '0;
        r_cmdDone <= 1'b0;
      end else begin
        if (r_state == CHK_CMD) begin
          r_rxShift <= {{(CW-2){1'b0}}, MOSI};
        end
        if (w_shiftIn) begin
          if (w_lastBit) begin
            r_cmdDone <= 1'b1;
            r_rxValid <= 1'b1;
            r_rxData  <= {r_rxShift, MOSI};
          end else begin
            r_rxShift <= {r_rxShift[CW-3:0], MOSI};
            r_bitCnt  <= r_bitCnt + 1'b1;
          end
        end
      end
    end
  end

  // Read-address flag. It is set by a completed READ_ADD word and cleared
  // only after a full read byte has been shifted out. An aborted frame
  // leaves it as it was.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdAddrFlag <= 1'b0;
    end else if (!SS_n) begin
      if (w_lastBit && (r_state == READ_ADD)) begin
        r_rdAddrFlag <= 1'b1;
      end else if (r_txBusy && (r_txCnt == LAST_CNT)) begin
        r_rdAddrFlag <= 1'b0;
      end
    end
  end

  // MISO serializer. On the capture edge the MSB goes straight to the
  // registered MISO, and the remaining bits are held left-aligned. r_txCnt
  // counts bits already presented. When it reaches DATA_W, MISO returns to 0
  // and the serializer locks out until the frame ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txShift <= '0;
      r_txCnt   <= '0;
      r_txBusy  <= 1'b0;
      r_txDone  <= 1'b0;
      r_miso    <= 1'b0;
    end else if (SS_n) begin
      r_txShift <= '0;
      r_txCnt   <= '0;
      r_txBusy  <= 1'b0;
      r_txDone  <= 1'b0;
      r_miso    <= 1'b0;
    end else if (w_txCapture) begin
      r_miso    <= tx_data[DATA_W-1];
      r_txShift <= {tx_data[DATA_W-2:0], 1'b0};
      r_txCnt   <= CNT_W'(1);
      r_txBusy  <= 1'b1;
    end else if (r_txBusy) begin
      if (r_txCnt == LAST_CNT) begin
        r_miso   <= 1'b0;
        r_txBusy <= 1'b0;
        r_txDone <= 1'b1;
      end else begin
        r_miso    <= r_txShift[DATA_W-1];
        r_txShift <= {r_txShift[DATA_W-2:0], 1'b0};
        r_txCnt   <= r_txCnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_slave
//   Directed self-checking bench for spi_slave (DATA_W = 8). Inputs are
//   driven on the falling edge. Outputs are sampled on the falling edge that
//   follows the rising edge of interest.
// ---------------------------------------------------------------------------
module tb_spi_slave;

  logic       clk;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int testsRun;
  int testsFailed;
  int validCount;
  int validBefore;

  logic [7:0] misoExp;

  spi_slave #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rx_valid pulses in the middle of each high phase
  initial validCount = 0;
  always @(posedge clk) begin
    #2;
    if (rx_valid === 1'b1) validCount++;
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one command word. Returns on the falling edge where rx_valid
  // should be visible, with SS_n still low.
  task automatic applyStimulus(input logic [9:0] word);
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = 1'b0;
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk);
      MOSI = word[i];
    end
    @(negedge clk);
  endtask

  // Single-cycle SS_n high pulse. The next applyStimulus lowers SS_n again.
  task automatic endFrame();
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n    = 1'b0;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset rx_data",  16'(rx_data), 16'h000);
    checkOutput("reset rx_valid", 16'(rx_valid), 16'h0);
    checkOutput("reset MISO",     16'(MISO), 16'h0);
    checkOutput("reset flag",     16'(dut.r_rdAddrFlag), 16'h0);
    checkOutput("reset state",    16'(dut.r_state), 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write address 0A5
    validBefore = validCount;
    applyStimulus(10'h0A5);
    checkOutput("wr-addr rx_valid", 16'(rx_valid), 16'h1);
    checkOutput("wr-addr rx_data",  16'(rx_data), 16'h0A5);
    endFrame();
    checkOutput("wr-addr strobe width", 16'(rx_valid), 16'h0);
    checkOutput("wr-addr pulse count",  16'(validCount - validBefore), 16'h1);
    checkOutput("wr-addr hold",         16'(rx_data), 16'h0A5);

    // Write data 3C, back-to-back after a single-cycle SS_n high
    validBefore = validCount;
    applyStimulus(10'h13C);
    checkOutput("wr-data rx_valid", 16'(rx_valid), 16'h1);
    checkOutput("wr-data rx_data",  16'(rx_data), 16'h13C);
    checkOutput("wr-data flag",     16'(dut.r_rdAddrFlag), 16'h0);

    // Extra MOSI bits after the word must be ignored
    for (int i = 0; i < 6; i++) begin
      MOSI = i[0];
      @(negedge clk);
    end
    checkOutput("extra bits rx_data",     16'(rx_data), 16'h13C);
    checkOutput("extra bits pulse count", 16'(validCount - validBefore), 16'h1);
    endFrame();

    // Read address 0A5 sets the flag
    applyStimulus(10'h2A5);
    checkOutput("rd-addr rx_valid", 16'(rx_valid), 16'h1);
    checkOutput("rd-addr rx_data",  16'(rx_data), 16'h2A5);
    checkOutput("rd-addr flag",     16'(dut.r_rdAddrFlag), 16'h1);
    endFrame();

    // Read data: tx_valid one cycle after rx_valid, held high throughout
    applyStimulus(10'h300);
    checkOutput("rd-data rx_valid", 16'(rx_valid), 16'h1);
    checkOutput("rd-data rx_data",  16'(rx_data), 16'h300);
    @(negedge clk);
    checkOutput("rd-data MISO idle", 16'(MISO), 16'h0);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    misoExp  = 8'b1100_0011;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      checkOutput($sformatf("rd-data MISO bit%0d", i), 16'(MISO), 16'(misoExp[i]));
    end
    @(negedge clk);
    checkOutput("rd-data MISO after", 16'(MISO), 16'h0);
    checkOutput("rd-data flag clear", 16'(dut.r_rdAddrFlag), 16'h0);
    tx_data = 8'hFF;
    repeat (3) @(negedge clk);
    checkOutput("rd-data no reload", 16'(MISO), 16'h0);
    tx_valid = 1'b0;
    endFrame();

    // Abort a READ_ADD frame after 5 bits
    validBefore = validCount;
    SS_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      MOSI = (i == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(negedge clk);
    checkOutput("abort state",       16'(dut.r_state), 16'h0);
    checkOutput("abort flag",        16'(dut.r_rdAddrFlag), 16'h0);
    checkOutput("abort pulse count", 16'(validCount - validBefore), 16'h0);
    checkOutput("abort rx_data",     16'(rx_data), 16'h300);

    // READ_DATA aborted mid-serialization leaves the flag set
    applyStimulus(10'h211);
    checkOutput("rd-addr2 flag", 16'(dut.r_rdAddrFlag), 16'h1);
    endFrame();
    applyStimulus(10'h300);
    @(negedge clk);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("ser-abort third bit", 16'(MISO), 16'h0);
    SS_n     = 1'b1;
    tx_valid = 1'b0;
    @(negedge clk);
    checkOutput("ser-abort MISO",  16'(MISO), 16'h0);
    checkOutput("ser-abort flag",  16'(dut.r_rdAddrFlag), 16'h1);
    checkOutput("ser-abort state", 16'(dut.r_state), 16'h0);

    // Reset during READ_DATA serialization after 3 bits (flag still set)
    applyStimulus(10'h300);
    checkOutput("rd-data3 state", 16'(dut.r_state), 16'h4);
    @(negedge clk);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("pre-reset MISO", 16'(MISO), 16'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset MISO",  16'(MISO), 16'h0);
    checkOutput("async reset flag",  16'(dut.r_rdAddrFlag), 16'h0);
    checkOutput("async reset state", 16'(dut.r_state), 16'h0);
    SS_n     = 1'b1;
    tx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // The next 1-prefixed frame must be treated as a read address
    applyStimulus(10'h25A);
    checkOutput("post-reset state",   16'(dut.r_state), 16'h3);
    checkOutput("post-reset rx_data", 16'(rx_data), 16'h25A);
    checkOutput("post-reset flag",    16'(dut.r_rdAddrFlag), 16'h1);
    endFrame();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
